// File: rtl/button_cmd_controller.sv
// Button front-end for the 0-9999 counter: sync, debounce, auto-repeat,
// arbitration and a valid/ready command offer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_up     raw button, 1 = pressed
//   btn_down   raw button, 1 = pressed
//   btn_clr    raw button, 1 = pressed
//   cmd_ready  counter accepts the offered command
//   cmd_valid  command offered
//   cmd_code   01 inc, 10 dec, 11 clear, 00 when idle
//   busy       a command is pending or being offered
module button_cmd_controller #(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8,
    parameter int REPEAT_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic       busy
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int STB_W  = $clog2(STABLE_TICKS + 1);
    localparam int REP_W  = $clog2(REPEAT_TICKS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STABLE_TICKS - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_INC  = 2'b01;
    localparam logic [1:0] CODE_DEC  = 2'b10;
    localparam logic [1:0] CODE_CLR  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    // Button vector order: [0] clear, [1] up, [2] down.
    logic [2:0]        raw;
    logic [2:0]        sync1;
    logic [2:0]        sync2;
    logic [2:0]        deb;
    logic [2:0]        deb_q;
    logic [STB_W-1:0]  stable_cnt [3];
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    // Repeat counters: [0] up, [1] down.
    logic [REP_W-1:0]  rep_cnt [2];
    logic [1:0]        rep_evt;
    logic [2:0]        press;
    logic [2:0]        set_evt;

    logic [2:0]        pend;
    logic [2:0]        pend_n;
    logic [2:0]        load_clr;

    state_t            state;
    state_t            state_n;
    logic [1:0]        code;
    logic [1:0]        code_n;

    assign raw  = {btn_down, btn_up, btn_clr};
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            tick_cnt <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // Debounce: a flip needs STABLE_TICKS consecutive disagreeing ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                stable_cnt[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            if (tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2[i] != deb[i]) begin
                        if (stable_cnt[i] == STB_LAST) begin
                            deb[i]        <= ~deb[i];
                            stable_cnt[i] <= '0;
                        end else begin
                            stable_cnt[i] <= stable_cnt[i] + STB_W'(1);
                        end
                    end else begin
                        stable_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        press   = deb & ~deb_q;
        rep_evt = '0;
        for (int j = 0; j < 2; j++) begin
            rep_evt[j] = deb[j+1] & ~press[j+1] & tick
                       & (rep_cnt[j] == REP_LAST);
        end
        set_evt = press | {rep_evt, 1'b0};
    end

    // A press restarts the repeat interval; a released button parks at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                rep_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!deb[j+1] || press[j+1]) begin
                    rep_cnt[j] <= '0;
                end else if (tick) begin
                    if (rep_cnt[j] == REP_LAST) begin
                        rep_cnt[j] <= '0;
                    end else begin
                        rep_cnt[j] <= rep_cnt[j] + REP_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        code_n   = code;
        load_clr = '0;
        case (state)
            ST_IDLE: begin
                if (pend[0]) begin
                    code_n      = CODE_CLR;
                    load_clr[0] = 1'b1;
                    state_n     = ST_OFFER;
                end else if (pend[1]) begin
                    code_n      = CODE_INC;
                    load_clr[1] = 1'b1;
                    state_n     = ST_OFFER;
                end else if (pend[2]) begin
                    code_n      = CODE_DEC;
                    load_clr[2] = 1'b1;
                    state_n     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) begin
                    code_n  = CODE_NONE;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                code_n  = CODE_NONE;
                state_n = ST_IDLE;
            end
        endcase
        // New event in the load cycle survives the clear.
        pend_n = set_evt | (pend & ~load_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            code  <= CODE_NONE;
            pend  <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
            pend  <= pend_n;
        end
    end

    assign cmd_valid = (state == ST_OFFER);
    assign cmd_code  = code;
    assign busy      = (|pend) | cmd_valid;

endmodule

// File: tb/tb_button_cmd_controller.sv
// Directed bench for button_cmd_controller with short tick/debounce/repeat
// parameters; each scenario task checks its own results.
module tb_button_cmd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_clr = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int xfer_code [$];
    int xfer_cyc [$];

    button_cmd_controller #(
        .TICK_DIV(4),
        .STABLE_TICKS(3),
        .REPEAT_TICKS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_clr(btn_clr),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Transfer log: sampled at the active edge, inputs move on negedge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cmd_valid && cmd_ready) begin
            xfer_code.push_back(int'(cmd_code));
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_clr = 1'b0;
        cmd_ready = 1'b0;
        run(3);
        rst = 1'b0;
        xfer_code.delete();
        xfer_cyc.delete();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        tests++;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", cmd_valid);
        end
        tests++;
        if (cmd_code !== 2'b00) begin
            fails++;
            $display("FAIL reset_code got %b want 00", cmd_code);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        bad = 0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || cmd_code !== 2'b00 || busy !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            btn_up = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        btn_up = 1'b0;
        run(20);
        tests++;
        if (xfer_code.size() != 0) begin
            fails++;
            $display("FAIL bounce_none got %0d xfers want 0",
                     xfer_code.size());
        end
        btn_up = 1'b1;
        run(16);
        btn_up = 1'b0;
        run(60);
        tests++;
        if (xfer_code.size() != 1) begin
            fails++;
            $display("FAIL press_once got %0d xfers want 1",
                     xfer_code.size());
        end else begin
            tests++;
            if (xfer_code[0] != 1) begin
                fails++;
                $display("FAIL press_code got %0d want 1", xfer_code[0]);
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        cmd_ready = 1'b1;
        btn_up = 1'b1;
        btn_clr = 1'b1;
        run(20);
        btn_up = 1'b0;
        btn_clr = 1'b0;
        run(60);
        tests++;
        if (xfer_code.size() < 2) begin
            fails++;
            $display("FAIL arb_count got %0d xfers want >=2",
                     xfer_code.size());
        end else begin
            tests++;
            if (xfer_code[0] != 3 || xfer_code[1] != 1) begin
                fails++;
                $display("FAIL arb_order got %0d,%0d want 3,1",
                         xfer_code[0], xfer_code[1]);
            end
            tests++;
            if (xfer_cyc[1] - xfer_cyc[0] != 2) begin
                fails++;
                $display("FAIL arb_gap got %0d clk want 2",
                         xfer_cyc[1] - xfer_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int first;
        int bad;
        int wrong;
        do_reset();
        first = -1;
        bad = 0;
        wrong = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1 && first < 0)
                first = c;
            if (first >= 0 && c < first + 60)
                if (!(cmd_valid === 1'b1 && cmd_code === 2'b10
                      && busy === 1'b1))
                    bad++;
            btn_down = (c < 16) || (c >= 50 && c < 66);
            cmd_ready = (first >= 0) && (c >= first + 59);
        end
        btn_down = 1'b0;
        tests++;
        if (first < 0) begin
            fails++;
            $display("FAIL stall_timeout got no cmd_valid want one");
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        tests++;
        if (xfer_code.size() != 2) begin
            fails++;
            $display("FAIL stall_merge got %0d xfers want 2",
                     xfer_code.size());
        end
        foreach (xfer_code[k])
            if (xfer_code[k] != 2)
                wrong++;
        tests++;
        if (wrong != 0) begin
            fails++;
            $display("FAIL stall_code got %0d non-dec want 0", wrong);
        end
    endtask

    task automatic test_repeat();
        int wrong;
        do_reset();
        wrong = 0;
        cmd_ready = 1'b1;
        for (int c = 0; c < 320; c++) begin
            btn_down = (c < 240);
            @(negedge clk);
        end
        tests++;
        if (xfer_code.size() < 11 || xfer_code.size() > 13) begin
            fails++;
            $display("FAIL repeat_count got %0d xfers want 11..13",
                     xfer_code.size());
        end
        foreach (xfer_code[k])
            if (xfer_code[k] != 2)
                wrong++;
        tests++;
        if (wrong != 0) begin
            fails++;
            $display("FAIL repeat_code got %0d non-dec want 0", wrong);
        end
        if (xfer_cyc.size() >= 3) begin
            tests++;
            if (xfer_cyc[2] - xfer_cyc[1] != 20) begin
                fails++;
                $display("FAIL repeat_period got %0d clk want 20",
                         xfer_cyc[2] - xfer_cyc[1]);
            end
        end
    endtask

    task automatic test_reset_offer();
        int found;
        int bad;
        do_reset();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            btn_up = (c < 16);
            @(negedge clk);
            if (cmd_valid === 1'b1)
                found = 1;
        end
        btn_up = 1'b0;
        run(4);
        tests++;
        if (cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL offer_before_rst got %b want 1", cmd_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xfer_code.delete();
        tests++;
        if (cmd_valid !== 1'b0 || cmd_code !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_drop got v=%b c=%b b=%b want 0 00 0",
                     cmd_valid, cmd_code, busy);
        end
        cmd_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0 || xfer_code.size() != 0) begin
            fails++;
            $display("FAIL rst_quiet got %0d bad, %0d xfers want 0,0",
                     bad, xfer_code.size());
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_arbitration();
        test_backpressure();
        test_repeat();
        test_reset_offer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
